input_port_route: RTL and testbench
===================================

INPUT_PORT_ROUTE -- requirements
Module: input_port_route

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter X_ADDR, default 2'd1, SHALL be the router's X coordinate in the 4x4 mesh.
REQ-003 Parameter Y_ADDR, default 2'd1, SHALL be the router's Y coordinate; Y increases northward.
REQ-004 clk  input  1  SHALL be the rising-edge clock.
REQ-005 rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-006 valid_i  input  1  SHALL mark a flit offered on the upstream link.
REQ-007 flit_i  input  32  SHALL be the flit; on a head flit, [31:30] = dest X and [29:28] = dest Y.
REQ-008 last_i  input  1  SHALL mark the tail flit of a packet; single-flit packets have last_i=1.
REQ-009 ready_o  output  1  SHALL indicate that the FIFO can accept a flit this cycle.
REQ-010 req_port_addr_o  output  3  SHALL be the requested output port, driven to the arbiter's req_port_addr input.
REQ-011 grant_i  input  1  SHALL be the arbiter's grant for this input port.
REQ-012 valid_o  output  1  SHALL mark a flit driven toward the crossbar.
REQ-013 flit_o  output  32  SHALL be the outgoing flit.
REQ-014 last_o  output  1  SHALL be the tail marker accompanying flit_o.

Function
REQ-015 Port codes SHALL be: 0 none, 1 north, 2 east, 3 south, 4 west, 5 local; codes 6-7 SHALL never be driven.
REQ-016 FIFO: 4 entries of {last, flit} (33 bits), 2-bit read/write pointers wrapping 3->0, 3-bit count 0..4.
REQ-017 ready_o SHALL be 1 iff count<4.
REQ-018 A push SHALL occur on a clock edge iff valid_i && ready_o; valid_i while ready_o=0 SHALL be dropped (the upstream holds it).
REQ-019 A pop SHALL occur iff valid_o=1.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 The FSM SHALL have three states: IDLE, REQ and XFER.
REQ-022 In IDLE with count>0, the next edge SHALL:
- load req_port_addr_o with the XY route of the FIFO head; and
- enter REQ.
REQ-023 XY route: dest X > X_ADDR -> 2; dest X < X_ADDR -> 4; else dest Y > Y_ADDR -> 1; dest Y < Y_ADDR -> 3; else -> 5.
REQ-024 In REQ, req_port_addr_o SHALL hold, and grant_i=1 at an edge SHALL enter XFER.
REQ-025 grant_i SHALL be ignored in IDLE and XFER.
REQ-026 In XFER, valid_o SHALL be (count>0), with flit_o and last_o taken combinationally from the FIFO head.
REQ-027 In XFER, when count=0, valid_o SHALL be 0 and the FSM SHALL stay in XFER (bubble).
REQ-028 In XFER, a pop with last=1 SHALL, at that edge:
- clear req_port_addr_o to 0; and
- enter IDLE.
REQ-029 In IDLE and REQ, valid_o SHALL be 0, and flit_o and last_o SHALL be 0.
REQ-030 Minimum latency for a flit accepted at edge E0 into an empty, IDLE block:
- req_port_addr_o is valid after E1;
- a grant sampled at E2 gives valid_o=1 after E2.
REQ-031 Flits of the next packet MAY be pushed during XFER; they SHALL route only after returning to IDLE.
REQ-032 Flits SHALL leave the block in arrival order, unmodified.

Reset
REQ-033 With rst_n=0 at a rising edge, the following SHALL be cleared:
- state IDLE;
- pointers and count 0;
- req_port_addr_o 0.
REQ-034 After reset, ready_o SHALL be 1, and valid_o, flit_o and last_o SHALL be 0.
REQ-035 Reset mid-packet (REQ or XFER) SHALL discard all buffered flits, with no partial output after reset.

Verification
REQ-036 X_ADDR=1, Y_ADDR=1. Push a single-flit packet with dest (3,0), then grant after one cycle in REQ:
- req_port_addr_o=2;
- one valid_o with last_o=1;
- then req_port_addr_o=0 and the FSM returns to IDLE.
REQ-037 Push head flits with dest (1,2), (1,0), (0,3) and (1,1), one packet each:
- req_port_addr_o sequence SHALL be 1, 3, 4, 5.
REQ-038 Push 5 flits back-to-back with no grant:
- ready_o=0 after the 4th push;
- the 5th flit is not accepted;
- count=4.
- Then grant: all 4 flits exit in order, and ready_o=1 after the first pop.
REQ-039 Push a 3-flit packet with a 2-cycle gap before the tail, after grant:
- valid_o has a bubble and req_port_addr_o stays nonzero;
- req_port_addr_o clears only after the tail pops.
REQ-040 Continuous push and pop in XFER for 8 flits:
- count stays constant; pointers wrap 3->0 with no loss or reorder.
REQ-041 Assert rst_n=0 in XFER with 2 flits buffered:
- next cycle valid_o=0, req_port_addr_o=0, ready_o=1;
- the stale flits never appear.

Source files
------------

// File: rtl/input_port_route.sv
// Mesh router input port: 4-deep flit FIFO plus XY route/request FSM.
// Ports: clk, rst_n (sync, active-low); upstream valid_i/flit_i/last_i/ready_o;
// arbiter req_port_addr_o/grant_i; crossbar valid_o/flit_o/last_o.
module input_port_route #(
  parameter logic [1:0] X_ADDR = 2'd1,
  parameter logic [1:0] Y_ADDR = 2'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] flit_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic [2:0]  req_port_addr_o,
  input  logic        grant_i,
  output logic        valid_o,
  output logic [31:0] flit_o,
  output logic        last_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam logic [2:0] P_NONE  = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;
  localparam logic [2:0] P_LOCAL = 3'd5;

  logic [32:0] mem_q [4];
  logic [1:0]  wr_q, wr_d;
  logic [1:0]  rd_q, rd_d;
  logic [2:0]  cnt_q, cnt_d;
  state_e      state_q;
  logic [2:0]  req_q;

  logic        push;
  logic        pop;
  logic [32:0] head;

  function automatic logic [2:0] route(
    input logic [1:0] dx,
    input logic [1:0] dy
  );
    logic [2:0] p;
    p = P_NONE;
    unique case (1'b1)
      (dx > X_ADDR):                   p = P_EAST;
      (dx < X_ADDR):                   p = P_WEST;
      (dx == X_ADDR && dy > Y_ADDR):   p = P_NORTH;
      (dx == X_ADDR && dy < Y_ADDR):   p = P_SOUTH;
      (dx == X_ADDR && dy == Y_ADDR):  p = P_LOCAL;
      default:                         p = P_NONE;
    endcase
    return p;
  endfunction

  assign head    = mem_q[rd_q];
  assign ready_o = (cnt_q < 3'd4);
  assign valid_o = (state_q == XFER) && (cnt_q != 3'd0);
  // Head is gated so idle/request states present zeros.
  assign flit_o  = valid_o ? head[31:0] : 32'd0;
  assign last_o  = valid_o & head[32];
  assign req_port_addr_o = req_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 2'd1;
    if (pop)  rd_d = rd_q + 2'd1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {last_i, flit_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= P_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q != 3'd0) begin
            req_q   <= route(head[31:30], head[29:28]);
            state_q <= REQ;
          end
        end
        REQ: begin
          if (grant_i) state_q <= XFER;
        end
        XFER: begin
          // An empty FIFO here is a bubble; the port stays owned.
          if (pop && head[32]) begin
            req_q   <= P_NONE;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= P_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_route.sv
// Directed bench for input_port_route with a flit scoreboard.
// Ports: drives and observes every DUT port.
module tb_input_port_route;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] flit_i = 32'd0;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic [2:0]  req_port_addr_o;
  logic        grant_i = 1'b0;
  logic        valid_o;
  logic [31:0] flit_o;
  logic        last_o;

  int ncmp = 0;
  int nerr = 0;
  int npop = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  input_port_route #(.X_ADDR(2'd1), .Y_ADDR(2'd1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(valid_i),
    .flit_i(flit_i),
    .last_i(last_i),
    .ready_o(ready_o),
    .req_port_addr_o(req_port_addr_o),
    .grant_i(grant_i),
    .valid_o(valid_o),
    .flit_o(flit_o),
    .last_o(last_o)
  );

  task automatic check(input string tag, input logic [32:0] obs,
                       input logic [32:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] dx,
                                     input logic [1:0] dy,
                                     input logic [27:0] pl);
    return {dx, dy, pl};
  endfunction

  // Scoreboard: predicts the coming edge from values seen mid-cycle.
  always @(negedge clk) begin
    logic acc;
    logic [32:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("ready", {32'd0, ready_o}, {32'd0, sb.size() < 4});
      acc = valid_i && (sb.size() < 4);
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("stray_flit", {last_o, flit_o}, 33'h0);
        end else begin
          e = sb.pop_front();
          check("flit_out", {last_o, flit_o}, e);
          npop++;
        end
      end
      if (acc) sb.push_back({last_i, flit_i});
    end
  end

  task automatic single(input logic [1:0] dx, input logic [1:0] dy,
                        input logic [2:0] exp, input string tag);
    valid_i = 1'b1; flit_i = mk(dx, dy, 28'hA0 + {26'd0, dx});
    last_i = 1'b1;
    tick();
    valid_i = 1'b0; last_i = 1'b0;
    tick();
    check({tag, "_req"}, {30'd0, req_port_addr_o}, {30'd0, exp});
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check({tag, "_vld"}, {32'd0, valid_o}, 33'd1);
    tick();
    check({tag, "_clr"}, {30'd0, req_port_addr_o}, 33'd0);
    check({tag, "_idle"}, {32'd0, valid_o}, 33'd0);
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ready", {32'd0, ready_o}, 33'd1);
    check("rst_valid", {32'd0, valid_o}, 33'd0);
    check("rst_out", {last_o, flit_o}, 33'd0);
    check("rst_req", {30'd0, req_port_addr_o}, 33'd0);

    // Single flit to (3,0): east, grant after one REQ cycle.
    valid_i = 1'b1; flit_i = mk(2'd3, 2'd0, 28'h1234567); last_i = 1'b1;
    tick();
    valid_i = 1'b0; last_i = 1'b0;
    check("t1_req0", {30'd0, req_port_addr_o}, 33'd0);
    tick();
    check("t1_req", {30'd0, req_port_addr_o}, 33'd2);
    check("t1_novld", {32'd0, valid_o}, 33'd0);
    tick();
    check("t1_hold", {30'd0, req_port_addr_o}, 33'd2);
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("t1_vld", {32'd0, valid_o}, 33'd1);
    check("t1_last", {32'd0, last_o}, 33'd1);
    tick();
    check("t1_clr", {30'd0, req_port_addr_o}, 33'd0);
    check("t1_done", {32'd0, valid_o}, 33'd0);

    single(2'd1, 2'd2, 3'd1, "north");
    single(2'd1, 2'd0, 3'd3, "south");
    single(2'd0, 2'd3, 3'd4, "west");
    single(2'd1, 2'd1, 3'd5, "local");

    // Overfill: 5 back-to-back, no grant.
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      flit_i = mk(2'd2, 2'd1, 28'h300 + i);
      last_i = (i >= 3);
      tick();
      if (i == 3) check("full_ready", {32'd0, ready_o}, 33'd0);
    end
    valid_i = 1'b0; last_i = 1'b0;
    check("full_cnt", {30'd0, dut.cnt_q}, 33'd4);
    check("full_req", {30'd0, req_port_addr_o}, 33'd2);
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("full_vld", {32'd0, valid_o}, 33'd1);
    tick();
    check("pop_ready", {32'd0, ready_o}, 33'd1);
    tick();
    tick();
    check("full_hold", {30'd0, req_port_addr_o}, 33'd2);
    tick();
    check("full_clr", {30'd0, req_port_addr_o}, 33'd0);

    // 3-flit packet with bubble before the tail.
    valid_i = 1'b1; flit_i = mk(2'd1, 2'd3, 28'h400); last_i = 1'b0;
    tick();
    flit_i = mk(2'd1, 2'd3, 28'h401);
    tick();
    valid_i = 1'b0;
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    tick();
    tick();
    check("bub_vld0", {32'd0, valid_o}, 33'd0);
    check("bub_req0", {30'd0, req_port_addr_o}, 33'd1);
    tick();
    check("bub_vld1", {32'd0, valid_o}, 33'd0);
    check("bub_req1", {30'd0, req_port_addr_o}, 33'd1);
    valid_i = 1'b1; flit_i = mk(2'd1, 2'd3, 28'h402); last_i = 1'b1;
    tick();
    valid_i = 1'b0; last_i = 1'b0;
    check("bub_tail", {32'd0, valid_o}, 33'd1);
    check("bub_req2", {30'd0, req_port_addr_o}, 33'd1);
    tick();
    check("bub_clr", {30'd0, req_port_addr_o}, 33'd0);

    // Streaming: 10-flit packet, push and pop together.
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1;
      flit_i = mk(2'd1, 2'd1, 28'h500 + i);
      last_i = (i == 9);
      grant_i = (i == 2);
      tick();
      if (i == 1) check("strm_req", {30'd0, req_port_addr_o}, 33'd5);
      if (i >= 2) begin
        check("strm_cnt", {30'd0, dut.cnt_q}, 33'd3);
        check("strm_vld", {32'd0, valid_o}, 33'd1);
      end
    end
    valid_i = 1'b0; last_i = 1'b0; grant_i = 1'b0;
    tick();
    tick();
    check("strm_hold", {30'd0, req_port_addr_o}, 33'd5);
    tick();
    check("strm_clr", {30'd0, req_port_addr_o}, 33'd0);

    // Reset while transferring with 2 flits buffered.
    valid_i = 1'b1; flit_i = mk(2'd0, 2'd1, 28'h600); last_i = 1'b0;
    tick();
    flit_i = mk(2'd0, 2'd1, 28'h601);
    tick();
    valid_i = 1'b0;
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("mr_vld", {32'd0, valid_o}, 33'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", {32'd0, valid_o}, 33'd0);
    check("mr_req", {30'd0, req_port_addr_o}, 33'd0);
    check("mr_ready", {32'd0, ready_o}, 33'd1);
    check("mr_out", {last_o, flit_o}, 33'd0);
    tick();
    tick();
    check("mr_quiet", {32'd0, valid_o}, 33'd0);
    single(2'd1, 2'd1, 3'd5, "post");

    tick();
    check("sb_empty", {1'b0, 32'(sb.size())}, 33'd0);
    check("pop_total", {1'b0, 32'(npop)}, 33'd23);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
